// File: rtl/ring_write_arbiter_pkg.sv
// Shared encodings and geometry for the 3-slot ring buffer, its write arbiter
// and the display-side reader.
package ring_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    COOL  = 2'b10
  } arb_state_e;

  localparam int DEPTH = 3;
  localparam int PTR_W = 2;

  // Slot index successor; the ring has DEPTH slots, so the last slot wraps to 0.
  function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/ring_write_arbiter_ring_ptr.sv
// Modulo-DEPTH slot pointer used for both the write and the read side of the ring.
module ring_ptr
  import ring_write_arbiter_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             adv_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i) begin
      ptr_d = ptrNext(ptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ring_write_arbiter.sv
// Round-robin arbiter for the ring buffer write port, with a post-write
// cool-down and occupancy tracking for the consumer side.
module ring_write_arbiter
  import ring_write_arbiter_pkg::*;
#(
  parameter int unsigned HOLD = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       req_i,
  input  logic [3:0]       data0_i,
  input  logic [3:0]       data1_i,
  input  logic             pop_i,
  output logic [1:0]       gnt_o,
  output logic             wr_en_o,
  output logic [PTR_W-1:0] wr_addr_o,
  output logic [3:0]       wr_data_o,
  output logic [PTR_W-1:0] rd_addr_o,
  output logic [1:0]       count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  arb_state_e       state_q, state_d;
  logic             winner_q, winner_d;
  logic             lastGnt_q, lastGnt_d;
  logic [3:0]       data_q, data_d;
  logic [7:0]       timer_q, timer_d;
  logic [1:0]       count_q, count_d;
  logic             wrAdv;
  logic             popOk;
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;

  assign wrAdv   = (state_q == GRANT);
  assign popOk   = pop_i && (count_q != 2'd0);
  assign full_o  = (count_q == 2'(DEPTH));
  assign empty_o = (count_q == 2'd0);

  ring_ptr u_wrPtr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv_i (wrAdv),
    .ptr_o (wrPtr)
  );

  ring_ptr u_rdPtr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .adv_i (popOk),
    .ptr_o (rdPtr)
  );

  // On a tie the requester that did not win last time is served.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    lastGnt_d = lastGnt_q;
    data_d    = data_q;
    timer_d   = timer_q;
    case (state_q)
      IDLE: begin
        if (!full_o && (req_i != 2'b00)) begin
          winner_d = (req_i == 2'b11) ? ~lastGnt_q : req_i[1];
          data_d   = winner_d ? data1_i : data0_i;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        lastGnt_d = winner_q;
        timer_d   = '0;
        state_d   = COOL;
      end
      COOL: begin
        timer_d = timer_q + 8'd1;
        if (timer_q == HOLD_M1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A write and an accepted pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    case ({wrAdv, popOk})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      winner_q  <= 1'b0;
      lastGnt_q <= 1'b1;
      data_q    <= '0;
      timer_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      winner_q  <= winner_d;
      lastGnt_q <= lastGnt_d;
      data_q    <= data_d;
      timer_q   <= timer_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    gnt_o     = 2'b00;
    wr_en_o   = 1'b0;
    wr_addr_o = '0;
    wr_data_o = '0;
    if (state_q == GRANT) begin
      gnt_o     = winner_q ? 2'b10 : 2'b01;
      wr_en_o   = 1'b1;
      wr_addr_o = wrPtr;
      wr_data_o = data_q;
    end
  end

  assign rd_addr_o = rdPtr;
  assign count_o   = count_q;

endmodule

// File: doc/ring_write_arbiter.md
# ring_write_arbiter

Round-robin write arbiter and occupancy controller for the shared 3-slot ring register buffer behind the 7-segment display path. Two requesters (e.g. debounced, edge-reduced load channels) compete for the buffer's single write port. The block picks a winner, drives the buffer's write port for one cycle, and enforces a fixed cool-down between writes. It tracks write/read pointers and fill count, and a consumer pops entries with a single-cycle strobe.

## Interface
- HOLD, 8: cool-down length in clock cycles after each write; legal range 1..255.
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  2  per-requester write request, level-sensitive; bit 0 = requester 0.
- data0  in  4  write data of requester 0.
- data1  in  4  write data of requester 1.
- pop  in  1  consumer read strobe; 1-cycle pulse removes the oldest entry.
- gnt  out  2  one-hot grant, high exactly during the write cycle.
- wr_en  out  1  buffer write enable.
- wr_addr  out  2  buffer write slot, 0..2.
- wr_data  out  4  buffer write data.
- rd_addr  out  2  slot holding the oldest entry, 0..2.
- count  out  2  occupied slots, 0..3.
- full  out  1  count == 3.
- empty  out  1  count == 0.

## Operation
- FSM states: IDLE, GRANT, COOL.
- IDLE: if full==0 and req!=0, pick the winner:
  - If only one requester is active, it wins.
  - If both are active, the requester other than last_gnt wins.
  - Latch the winner index and its data into data_q. Next state is GRANT.
  - If full==1, stay in IDLE and assert no grant.
- GRANT (exactly 1 cycle):
  - gnt = one-hot(winner), wr_en=1, wr_addr=wr_ptr, wr_data=data_q.
  - On the closing edge: wr_ptr advances (2 wraps to 0), count+1, last_gnt=winner, timer=0. Next state is COOL.
- COOL: timer increments each cycle. When timer==HOLD-1, return to IDLE. gnt=0, wr_en=0.
- pop is accepted in any state when count>0: rd_ptr advances (2 wraps to 0), count-1. pop while empty is ignored, with no pointer or count change.
- Simultaneous GRANT write and accepted pop: count unchanged, both pointers advance.
- Dropping req after the IDLE decision does not cancel the write. Data is the value latched in IDLE; data changes during GRANT are ignored.
- A requester holding req high is served again only after COOL ends, and loses any tie to the other requester.
- gnt, wr_en, wr_addr and wr_data are decoded from registered state only, with no combinational path from req or pop. count, full, empty and rd_addr are registered.
- Reset values: state IDLE, wr_ptr=0, rd_ptr=0, count=0, last_gnt=1 (requester 0 wins the first tie), timer=0, data_q=0.
- Reset output values: gnt=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, count=0, full=0, empty=1.

## Timing
- req sampled high in IDLE at edge k: gnt/wr_en are high from edge k to edge k+1, and the buffer captures on edge k+1.
- Minimum spacing between grants: 1 + HOLD + 1 cycles (GRANT, HOLD cycles of COOL, one IDLE decision cycle). With HOLD=8, writes are 10 cycles apart under continuous request.
- pop at edge k: count, rd_addr and empty update at edge k.
- rst asserted at any point, including mid-GRANT or mid-COOL, forces reset values immediately with no clock needed. A write in flight is lost, and the buffer contents are not owned by this block.
- count arithmetic is 2-bit saturating by construction. Writes are blocked at 3, and pops are ignored at 0.
- timer is 8 bits wide. The compare is timer == HOLD-1.

## Structure
- Shared package:
  - state encoding constants: IDLE=2'b00, GRANT=2'b01, COOL=2'b10.
  - DEPTH=3.
  - pointer width 2.
  - These are shared with the buffer/display block.
- One sub-module: ring_ptr, a 2-bit 0..2 wrap counter with an advance input and async active-high reset. It is instantiated twice, for wr_ptr and rd_ptr.
- Arbitration, count and timer live in the top module.

## Test plan
- After reset, req=2'b11, data0=4'h5, data1=4'hA: gnt=01, wr_addr=0, wr_data=5 one cycle later. Ten cycles later gnt=10, wr_addr=1, wr_data=A. count goes 1 then 2.
- Three consecutive grants from empty: full=1, count=3. With req held, there is no gnt for 20 cycles. One pop gives count=2, rd_addr=1. The next grant writes wr_addr=0 (wrap).
- count=1 and pop coincides with the GRANT cycle: count stays 1, rd_addr and wr_ptr both advance.
- pop while empty: count=0, rd_addr=0, empty=1, all unchanged.
- req0 pulsed for 1 cycle in IDLE, and data0 changed during GRANT: the write still occurs with the data sampled in IDLE.
- rst asserted during COOL with count=2: all outputs return to reset values immediately. The first grant after reset goes to requester 0 on a tie.
